// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM state and read-owner encodings.
package mem_arbiter_pkg;

  // Arbitration mode: normal per-cycle arbitration or debug-owned bus.
  typedef enum logic {
    ARB_S  = 1'b0,
    LOCK_S = 1'b1
  } arb_state_e;

  // Which port owns the read data returning from memory this cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2
  } owner_e;

  // Width of the debug starvation counter.
  localparam int WAIT_W = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU/debug requesters, the arbiter and the RAM port.
// The arbiter connects through the slave modport; the requesters and RAM
// model sit on the master side.
interface mem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  // CPU port
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_stall;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  // Debug/loader port
  logic          dbg_req;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_lock;
  logic          dbg_gnt;
  logic          dbg_rvalid;
  logic [DW-1:0] dbg_rdata;
  // Memory port
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/mem_arb_starve.sv
// Debug starvation guard: counts consecutive cycles in which debug is denied
// and raises force_dbg_o once the count reaches MAX_WAIT.
// Only compiled and used when MEM_ARB_STARVE_EN is defined.
`ifdef MEM_ARB_STARVE_EN
module mem_arb_starve
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic dbg_req_i,
  input  logic dbg_gnt_i,
  output logic force_dbg_o
);

  localparam logic [WAIT_W-1:0] MaxWaitC = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] wait_cnt_q;
  logic [WAIT_W-1:0] wait_cnt_d;

  // Saturating count of denied debug cycles; any grant or idle cycle clears it.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!dbg_req_i || dbg_gnt_i) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != MaxWaitC) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign force_dbg_o = (wait_cnt_q == MaxWaitC);

endmodule
`endif

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between the CPU memory path and a debug/loader
// port. Fixed CPU priority, debug bus lock for bursts, registered read owner
// tag for steering returned data.
// Optional feature macro: MEM_ARB_STARVE_EN enables the debug starvation
// guard (mem_arb_starve); without it CPU has strict priority outside LOCK.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int MAX_WAIT = 4
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_max_wait_range
    $error("mem_arbiter: MAX_WAIT must be in 1..15");
  end

  arb_state_e    state_q, state_d;
  owner_e        owner_q, owner_d;
  logic          cpu_gnt, dbg_gnt;
  logic          force_dbg;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;

`ifdef MEM_ARB_STARVE_EN
  mem_arb_starve #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .clk         (clk),
    .rst         (rst),
    .dbg_req_i   (bus.dbg_req),
    .dbg_gnt_i   (dbg_gnt),
    .force_dbg_o (force_dbg)
  );
`else
  assign force_dbg = 1'b0;
`endif

  // Grant decision and lock FSM next state.
  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    state_d = state_q;
    unique case (state_q)
      ARB_S: begin
        if (bus.dbg_req && (!bus.cpu_req || force_dbg)) begin
          dbg_gnt = 1'b1;
        end else if (bus.cpu_req) begin
          cpu_gnt = 1'b1;
        end
        if (dbg_gnt && bus.dbg_lock) begin
          state_d = LOCK_S;
        end
      end
      LOCK_S: begin
        // The unlocking cycle itself is still debug-only.
        dbg_gnt = bus.dbg_req;
        if (!bus.dbg_lock) begin
          state_d = ARB_S;
        end
      end
      default: state_d = ARB_S;
    endcase
  end

  // Memory port mux from the granted requester; idle bus is all zero.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    owner_d   = OWN_NONE;
    if (cpu_gnt) begin
      mem_en    = 1'b1;
      mem_we    = bus.cpu_we;
      mem_addr  = bus.cpu_addr;
      mem_wdata = bus.cpu_wdata;
      if (!bus.cpu_we) owner_d = OWN_CPU;
    end else if (dbg_gnt) begin
      mem_en    = 1'b1;
      mem_we    = bus.dbg_we;
      mem_addr  = bus.dbg_addr;
      mem_wdata = bus.dbg_wdata;
      if (!bus.dbg_we) owner_d = OWN_DBG;
    end
  end

  // State and read-owner registers; reset drops any read in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB_S;
      owner_q <= OWN_NONE;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.cpu_stall  = bus.cpu_req & ~cpu_gnt;
  assign bus.dbg_gnt    = dbg_gnt;
  assign bus.mem_en     = mem_en;
  assign bus.mem_we     = mem_we;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_wdata  = mem_wdata;
  assign bus.cpu_rvalid = (owner_q == OWN_CPU);
  assign bus.dbg_rvalid = (owner_q == OWN_DBG);
  assign bus.cpu_rdata  = (owner_q == OWN_CPU) ? bus.mem_rdata : '0;
  assign bus.dbg_rdata  = (owner_q == OWN_DBG) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter. Expectations adapt to MEM_ARB_STARVE_EN.
module tb_mem_arbiter;

`ifdef MEM_ARB_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(16), .DW(16)) bus ();

  mem_arbiter #(
    .AW       (16),
    .DW       (16),
    .MAX_WAIT (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
    bus.dbg_lock = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_drive(input logic we, input logic [15:0] addr, input logic [15:0] wd);
    bus.cpu_req = 1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wd;
  endtask

  task automatic dbg_drive(input logic we, input logic [15:0] addr, input logic [15:0] wd,
                           input logic lock);
    bus.dbg_req = 1; bus.dbg_we = we; bus.dbg_addr = addr; bus.dbg_wdata = wd;
    bus.dbg_lock = lock;
  endtask

  initial begin
    logic exp_dbg;
    idle();
    bus.mem_rdata = '0;

    // Reset state
    rst = 0;
    #12;
    chk("rst_cpu_rvalid", bus.cpu_rvalid, 0);
    chk("rst_dbg_rvalid", bus.dbg_rvalid, 0);
    next_cycle();
    rst = 1;
    @(negedge clk);
    chk("idle_cpu_gnt", bus.cpu_gnt, 0);
    chk("idle_dbg_gnt", bus.dbg_gnt, 0);
    chk("idle_mem_en", bus.mem_en, 0);
    chk("idle_mem_addr", bus.mem_addr, 0);
    chk("idle_cpu_stall", bus.cpu_stall, 0);

    // Single CPU read
    next_cycle();
    cpu_drive(0, 16'h0010, 16'h0);
    @(negedge clk);
    chk("rd_cpu_gnt", bus.cpu_gnt, 1);
    chk("rd_mem_en", bus.mem_en, 1);
    chk("rd_mem_we", bus.mem_we, 0);
    chk("rd_mem_addr", bus.mem_addr, 16'h0010);
    chk("rd_cpu_stall", bus.cpu_stall, 0);
    next_cycle();
    idle();
    bus.mem_rdata = 16'hBEEF;
    @(negedge clk);
    chk("rd_cpu_rvalid", bus.cpu_rvalid, 1);
    chk("rd_cpu_rdata", bus.cpu_rdata, 16'hBEEF);
    chk("rd_dbg_rvalid", bus.dbg_rvalid, 0);
    chk("rd_dbg_rdata", bus.dbg_rdata, 0);
    next_cycle();
    @(negedge clk);
    chk("rd_rvalid_once", bus.cpu_rvalid, 0);

    // Both requesting continuously: debug forced through on cycle 4 if guarded
    next_cycle();
    cpu_drive(1, 16'h0100, 16'hAAAA);
    dbg_drive(1, 16'h0200, 16'h5555, 0);
    for (int i = 0; i < 6; i++) begin
      exp_dbg = STARVE && (i == 4);
      @(negedge clk);
      chk($sformatf("starve_dbg_gnt_%0d", i), bus.dbg_gnt, exp_dbg);
      chk($sformatf("starve_cpu_gnt_%0d", i), bus.cpu_gnt, !exp_dbg);
      chk($sformatf("starve_stall_%0d", i), bus.cpu_stall, exp_dbg);
      chk($sformatf("starve_addr_%0d", i), bus.mem_addr, exp_dbg ? 16'h0200 : 16'h0100);
      next_cycle();
    end
    idle();
    next_cycle();

    // Locked debug burst
    dbg_drive(1, 16'h0020, 16'h1234, 1);
    @(negedge clk);
    chk("lk0_dbg_gnt", bus.dbg_gnt, 1);
    chk("lk0_mem_we", bus.mem_we, 1);
    chk("lk0_mem_addr", bus.mem_addr, 16'h0020);
    chk("lk0_mem_wdata", bus.mem_wdata, 16'h1234);
    chk("lk0_cpu_gnt", bus.cpu_gnt, 0);
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      cpu_drive(0, 16'h0050, 16'h0);
      dbg_drive(1, 16'h0020 + 16'(k), 16'h1234 + 16'(k), (k < 4));
      @(negedge clk);
      chk($sformatf("lk%0d_dbg_gnt", k), bus.dbg_gnt, 1);
      chk($sformatf("lk%0d_cpu_stall", k), bus.cpu_stall, 1);
      chk($sformatf("lk%0d_mem_addr", k), bus.mem_addr, 16'h0020 + k);
    end
    next_cycle();
    dbg_drive(1, 16'h0030, 16'h0, 1);
    @(negedge clk);
    chk("unlock_cpu_gnt", bus.cpu_gnt, 1);
    chk("unlock_dbg_gnt", bus.dbg_gnt, 0);
    chk("unlock_mem_addr", bus.mem_addr, 16'h0050);
    next_cycle();
    idle();
    bus.mem_rdata = 16'h0A0A;
    @(negedge clk);
    chk("unlock_cpu_rvalid", bus.cpu_rvalid, 1);
    chk("unlock_cpu_rdata", bus.cpu_rdata, 16'h0A0A);
    next_cycle();

    // Alternating reads CPU, debug, CPU
    cpu_drive(0, 16'h0030, 16'h0);
    @(negedge clk);
    chk("alt0_cpu_gnt", bus.cpu_gnt, 1);
    next_cycle();
    idle();
    dbg_drive(0, 16'h0040, 16'h0, 0);
    bus.mem_rdata = 16'h1111;
    @(negedge clk);
    chk("alt1_dbg_gnt", bus.dbg_gnt, 1);
    chk("alt1_cpu_rvalid", bus.cpu_rvalid, 1);
    chk("alt1_cpu_rdata", bus.cpu_rdata, 16'h1111);
    chk("alt1_dbg_rvalid", bus.dbg_rvalid, 0);
    next_cycle();
    idle();
    cpu_drive(0, 16'h0031, 16'h0);
    bus.mem_rdata = 16'h2222;
    @(negedge clk);
    chk("alt2_cpu_gnt", bus.cpu_gnt, 1);
    chk("alt2_dbg_rvalid", bus.dbg_rvalid, 1);
    chk("alt2_dbg_rdata", bus.dbg_rdata, 16'h2222);
    chk("alt2_cpu_rvalid", bus.cpu_rvalid, 0);
    chk("alt2_cpu_rdata", bus.cpu_rdata, 0);
    next_cycle();
    idle();
    bus.mem_rdata = 16'h3333;
    @(negedge clk);
    chk("alt3_cpu_rvalid", bus.cpu_rvalid, 1);
    chk("alt3_cpu_rdata", bus.cpu_rdata, 16'h3333);
    chk("alt3_dbg_rvalid", bus.dbg_rvalid, 0);
    next_cycle();

    // Reset one cycle after a CPU read grant drops the read
    cpu_drive(0, 16'h0060, 16'h0);
    @(negedge clk);
    chk("rr_cpu_gnt", bus.cpu_gnt, 1);
    next_cycle();
    idle();
    rst = 0;
    bus.mem_rdata = 16'hDEAD;
    #1;
    chk("rr_in_reset_rvalid", bus.cpu_rvalid, 0);
    next_cycle();
    rst = 1;
    @(negedge clk);
    chk("rr_after_rvalid", bus.cpu_rvalid, 0);
    next_cycle();

    // Reset during LOCK clears the lock
    dbg_drive(1, 16'h0070, 16'h7777, 1);
    @(negedge clk);
    chk("rl_dbg_gnt", bus.dbg_gnt, 1);
    next_cycle();
    idle();
    bus.dbg_lock = 1;
    cpu_drive(0, 16'h0080, 16'h0);
    @(negedge clk);
    chk("rl_locked_stall", bus.cpu_stall, 1);
    next_cycle();
    rst = 0;
    next_cycle();
    rst = 1;
    dbg_drive(1, 16'h0090, 16'h0, 1);
    @(negedge clk);
    chk("rl_cpu_gnt", bus.cpu_gnt, 1);
    chk("rl_dbg_gnt_after", bus.dbg_gnt, 0);
    next_cycle();
    idle();
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
